// File: rtl/filter_win_ctrl_5x5.sv
// Window sequencer for the 5x5 filter datapath: line-buffer write control, window
// read scheduling and per-tap zero-padding mask, one output per image pixel.
module filter_win_ctrl_5x5 #(
  parameter int MAX_W_BITS = 11,
  parameter int MAX_H_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [MAX_W_BITS-1:0] i_width,
  input  logic [MAX_H_BITS-1:0] i_height,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic                  o_lb_wr_en,
  output logic [MAX_W_BITS-1:0] o_lb_wr_addr,
  output logic [2:0]            o_lb_wr_sel,
  output logic [MAX_W_BITS-1:0] o_lb_rd_addr,
  output logic [2:0]            o_lb_rd_base,
  output logic                  o_en,
  output logic [24:0]           o_mask,
  output logic [MAX_W_BITS-1:0] o_out_x,
  output logic [MAX_H_BITS-1:0] o_out_y,
  output logic                  o_busy,
  output logic                  o_done
);

  // state    | meaning
  // IDLE     | waiting for a valid i_start
  // RUN      | accepting pixels, window issued per accept once two rows/cols are in
  // COLFLUSH | two cycles finishing the right edge of the current output row
  // ROWFLUSH | emitting the last two output rows with no further input
  // DONE     | raises o_done next cycle and returns to IDLE
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_COLFLUSH, S_ROWFLUSH, S_DONE} state_t;

  localparam logic [MAX_W_BITS-1:0] W1 = MAX_W_BITS'(1);
  localparam logic [MAX_W_BITS-1:0] W2 = MAX_W_BITS'(2);
  localparam logic [MAX_W_BITS-1:0] W3 = MAX_W_BITS'(3);
  localparam logic [MAX_H_BITS-1:0] H1 = MAX_H_BITS'(1);
  localparam logic [MAX_H_BITS-1:0] H2 = MAX_H_BITS'(2);
  localparam logic [MAX_H_BITS-1:0] H3 = MAX_H_BITS'(3);

  function automatic logic [2:0] inc5(input logic [2:0] s);
    return (s == 3'd4) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [24:0] mask_f(input logic [MAX_W_BITS-1:0] x,
                                         input logic [MAX_H_BITS-1:0] y,
                                         input logic [MAX_W_BITS-1:0] w,
                                         input logic [MAX_H_BITS-1:0] h);
    logic [24:0] m;
    m = '0;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        m[(dy+2)*5 + (dx+2)] = (int'(x) + dx >= 0) && (int'(x) + dx <= int'(w) - 1) &&
                               (int'(y) + dy >= 0) && (int'(y) + dy <= int'(h) - 1);
      end
    end
    return m;
  endfunction

  state_t                state_q;
  logic [MAX_W_BITS-1:0] w_q, c_q, fx_q;
  logic [MAX_H_BITS-1:0] h_q, r_q, fy_q;
  logic [2:0]            row_sel_q, fsel_q;
  logic                  cf_q;
  logic                  busy_q, done_q, en_q;
  logic [24:0]           mask_q;
  logic [MAX_W_BITS-1:0] x_q, rd_addr_q;
  logic [MAX_H_BITS-1:0] y_q;
  logic [2:0]            rd_base_q;

  logic                  accept;
  logic                  win_en_d;
  logic [MAX_W_BITS-1:0] win_x_d, rd_addr_d;
  logic [MAX_H_BITS-1:0] win_y_d;
  logic [2:0]            win_base_d;
  logic [MAX_W_BITS:0]   xp2_d;

  assign o_in_ready   = (state_q == S_RUN);
  assign accept       = i_in_valid & o_in_ready;
  assign o_lb_wr_en   = accept;
  assign o_lb_wr_addr = c_q;
  assign o_lb_wr_sel  = row_sel_q;
  assign o_lb_rd_addr = rd_addr_q;
  assign o_lb_rd_base = rd_base_q;
  assign o_en         = en_q;
  assign o_mask       = mask_q;
  assign o_out_x      = x_q;
  assign o_out_y      = y_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

  // Read base (y+3) mod 5 is derived from the row-select counter rather than a divider.
  always_comb begin
    win_en_d   = 1'b0;
    win_x_d    = x_q;
    win_y_d    = y_q;
    win_base_d = rd_base_q;
    unique case (state_q)
      S_RUN: begin
        if (accept && r_q >= H2 && c_q >= W2) begin
          win_en_d   = 1'b1;
          win_x_d    = c_q - W2;
          win_y_d    = r_q - H2;
          win_base_d = inc5(row_sel_q);
        end
      end
      S_COLFLUSH: begin
        win_en_d   = 1'b1;
        win_x_d    = w_q - W2 + {{(MAX_W_BITS-1){1'b0}}, cf_q};
        win_y_d    = r_q - H3;
        win_base_d = row_sel_q;
      end
      S_ROWFLUSH: begin
        win_en_d   = 1'b1;
        win_x_d    = fx_q;
        win_y_d    = fy_q;
        win_base_d = fsel_q;
      end
      default: ;
    endcase
    xp2_d     = {1'b0, win_x_d} + {1'b0, W2};
    rd_addr_d = (xp2_d >= {1'b0, w_q}) ? w_q - W1 : xp2_d[MAX_W_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      row_sel_q <= '0;
      fsel_q    <= '0;
      cf_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      mask_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rd_addr_q <= '0;
      rd_base_q <= '0;
    end else begin
      done_q <= 1'b0;
      en_q   <= win_en_d;
      if (win_en_d) begin
        x_q       <= win_x_d;
        y_q       <= win_y_d;
        mask_q    <= mask_f(win_x_d, win_y_d, w_q, h_q);
        rd_addr_q <= rd_addr_d;
        rd_base_q <= win_base_d;
      end
      unique case (state_q)
        S_IDLE: begin
          if (i_start && i_width >= W3 && i_height >= H3) begin
            w_q       <= i_width;
            h_q       <= i_height;
            c_q       <= '0;
            r_q       <= '0;
            row_sel_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (c_q == w_q - W1) begin
              c_q       <= '0;
              r_q       <= r_q + H1;
              row_sel_q <= inc5(row_sel_q);
              if (r_q >= H2) begin
                cf_q    <= 1'b0;
                state_q <= S_COLFLUSH;
              end
            end else begin
              c_q <= c_q + W1;
            end
          end
        end
        S_COLFLUSH: begin
          cf_q <= 1'b1;
          if (cf_q) begin
            // r has already advanced past the row just written, so r==H marks the last row.
            if (r_q == h_q) begin
              fx_q    <= '0;
              fy_q    <= h_q - H2;
              fsel_q  <= inc5(row_sel_q);
              state_q <= S_ROWFLUSH;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_ROWFLUSH: begin
          if (fx_q == w_q - W1) begin
            fx_q <= '0;
            if (fy_q == h_q - H1) begin
              state_q <= S_DONE;
            end else begin
              fy_q   <= fy_q + H1;
              fsel_q <= inc5(fsel_q);
            end
          end else begin
            fx_q <= fx_q + W1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_win_ctrl_5x5.sv
// Randomized bench for filter_win_ctrl_5x5: each frame's window sequence is predicted
// in raster order from the image geometry and compared against the DUT.
module tb_filter_win_ctrl_5x5;
  localparam int WB = 11;
  localparam int HB = 11;

  logic          clk = 1'b0;
  logic          rst, i_start, i_in_valid;
  logic [WB-1:0] i_width;
  logic [HB-1:0] i_height;
  logic          o_in_ready, o_lb_wr_en, o_en, o_busy, o_done;
  logic [WB-1:0] o_lb_wr_addr, o_lb_rd_addr, o_out_x;
  logic [HB-1:0] o_out_y;
  logic [2:0]    o_lb_wr_sel, o_lb_rd_base;
  logic [24:0]   o_mask;

  filter_win_ctrl_5x5 #(.MAX_W_BITS(WB), .MAX_H_BITS(HB)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_lb_wr_en(o_lb_wr_en),
    .o_lb_wr_addr(o_lb_wr_addr), .o_lb_wr_sel(o_lb_wr_sel), .o_lb_rd_addr(o_lb_rd_addr),
    .o_lb_rd_base(o_lb_rd_base), .o_en(o_en), .o_mask(o_mask), .o_out_x(o_out_x),
    .o_out_y(o_out_y), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [24:0] mask;
    int          addr;
    int          base;
  } win_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [24:0] ref_mask(input int x, input int y, input int w, input int h);
    logic [24:0] m = '0;
    for (int ty = y - 2; ty <= y + 2; ty++)
      for (int tx = x - 2; tx <= x + 2; tx++)
        if (tx >= 0 && tx < w && ty >= 0 && ty < h)
          m[(ty - y + 2) * 5 + (tx - x + 2)] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_ready"},   32'(o_in_ready),   0);
    check_eq({pfx, "_en"},      32'(o_en),         0);
    check_eq({pfx, "_mask"},    32'(o_mask),       0);
    check_eq({pfx, "_x"},       32'(o_out_x),      0);
    check_eq({pfx, "_y"},       32'(o_out_y),      0);
    check_eq({pfx, "_rd_addr"}, 32'(o_lb_rd_addr), 0);
    check_eq({pfx, "_rd_base"}, 32'(o_lb_rd_base), 0);
    check_eq({pfx, "_busy"},    32'(o_busy),       0);
    check_eq({pfx, "_done"},    32'(o_done),       0);
  endtask

  task automatic run_frame(input int w, input int h, input int pct,
                           input bit abort_rf, input bit mid_start);
    win_t q[$];
    win_t e;
    int   acc = 0, outs = 0, it = 0, first = -1, done_it = -1, low = 0;
    int   budget = 4 * w * h + 4 * w + 4 * h + 50;
    bit   prev_ready = 0, prev_acc = 0, acc_now;

    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        e.x = x; e.y = y; e.mask = ref_mask(x, y, w, h);
        e.addr = (x + 2 > w - 1) ? w - 1 : x + 2;
        e.base = (y + 3) % 5;
        q.push_back(e);
      end

    @(negedge clk);
    i_start = 1'b1; i_width = WB'(w); i_height = HB'(h);
    @(negedge clk);
    i_start = 1'b0;
    check_eq("busy_rise", 32'(o_busy), 1);

    while (done_it < 0 && it < budget) begin
      if (o_en) begin
        if (prev_ready && !prev_acc) check_eq("no_en_bubble", 32'(o_en), 0);
        if (q.size() == 0) begin
          check_eq("extra_output", 32'(o_en), 0);
        end else begin
          e = q.pop_front();
          check_eq("out_x",   32'(o_out_x),      32'(e.x));
          check_eq("out_y",   32'(o_out_y),      32'(e.y));
          check_eq("mask",    32'(o_mask),       32'(e.mask));
          check_eq("rd_addr", 32'(o_lb_rd_addr), 32'(e.addr));
          check_eq("rd_base", 32'(o_lb_rd_base), 32'(e.base));
          outs++;
        end
      end
      if (o_done) begin
        done_it = it;
        check_eq("busy_fall", 32'(o_busy), 0);
      end else if (first >= 0 && !o_in_ready) begin
        low++;
      end

      if (done_it < 0 && abort_rf && outs >= w * (h - 2) + 2) begin
        rst = 1'b1; i_in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1'b0;
        for (int k = 0; k < 2 * w + 5; k++) begin
          @(negedge clk);
          check_eq("no_done_after_rst", 32'(o_done), 0);
        end
        return;
      end

      if (done_it < 0) begin
        i_start    = mid_start && acc == 7;
        i_width    = i_start ? WB'(w + 3) : WB'(w);
        i_in_valid = ($urandom_range(99) < pct);
        #1;
        acc_now = i_in_valid & o_in_ready;
        check_eq("wr_en", 32'(o_lb_wr_en), 32'(acc_now));
        if (acc_now) begin
          if (first < 0) first = it;
          check_eq("wr_addr", 32'(o_lb_wr_addr), 32'(acc % w));
          check_eq("wr_sel",  32'(o_lb_wr_sel),  32'((acc / w) % 5));
          acc++;
        end
        prev_ready = o_in_ready;
        prev_acc   = acc_now;
        @(negedge clk);
        it++;
      end
    end

    i_in_valid = 1'b0; i_start = 1'b0;
    if (done_it < 0) begin
      check_eq("done_timeout", 0, 1);
    end else begin
      check_eq("accepts", 32'(acc), 32'(w * h));
      check_eq("outputs", 32'(outs), 32'(w * h));
      if (pct >= 100) begin
        check_eq("done_latency", 32'(done_it - first), 32'(w * h + 2 * (h - 2) + 2 * w + 1));
        check_eq("ready_low_cycles", 32'(low), 32'(2 * (h - 2) + 2 * w + 1));
      end
      @(negedge clk);
      check_eq("done_pulse_width", 32'(o_done), 0);
    end
  endtask

  task automatic try_bad_start(input int w, input int h);
    @(negedge clk);
    i_start = 1'b1; i_width = WB'(w); i_height = HB'(h);
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("bad_start_busy",  32'(o_busy),     0);
      check_eq("bad_start_ready", 32'(o_in_ready), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_in_valid = 1'b0; i_width = '0; i_height = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    try_bad_start(2, 5);
    try_bad_start(5, 2);

    run_frame(5, 5, 100, 1'b0, 1'b0);
    run_frame(8, 6, 100, 1'b0, 1'b1);
    run_frame(7, 4, 100, 1'b0, 1'b0);
    run_frame(7, 4, 50,  1'b0, 1'b0);
    run_frame(6, 5, 100, 1'b1, 1'b0);
    run_frame(6, 5, 70,  1'b0, 1'b0);
    run_frame(3, 3, 100, 1'b0, 1'b0);
    run_frame(4, 7, 40,  1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
